// File: rtl/rstack.sv
// rtl/rstack.sv - Forth return stack with registered top entry and spill array
// Top lives in its own register so rstack_top never depends on an array read.
module rstack #(
  parameter int iaddr_width = 10,
  parameter int data_width  = 16,
  parameter int depth       = 16,
  parameter int ptr_width   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [iaddr_width-1:0] ip_inc,
  input  logic [data_width-1:0]  TOS,
  input  logic                   push,
  input  logic                   push_tos_sel,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic [data_width-1:0]  rstack_top,
  output logic [iaddr_width-1:0] rstack_top_ip,
  output logic [ptr_width-1:0]   count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int aw = (depth > 2) ? $clog2(depth - 1) : 1;
  localparam logic [ptr_width-1:0] depth_c = ptr_width'(depth);

  logic [data_width-1:0] top_q, top_d;
  logic [ptr_width-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [data_width-1:0] mem_q [2**aw];

  logic [data_width-1:0] push_data;
  logic                  wr_en;
  logic                  ovf_set, unf_set;
  logic [aw-1:0]         wr_idx, rd_idx;
  logic                  is_full, is_empty;

  assign is_full  = (count_q == depth_c);
  assign is_empty = (count_q == '0);
  assign wr_idx   = aw'(count_q - ptr_width'(1));
  assign rd_idx   = aw'(count_q - ptr_width'(2));

  always_comb begin
    push_data = push_tos_sel ? TOS : data_width'(ip_inc);
    top_d     = top_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (push && pop) begin
      top_d = push_data;
      if (is_empty) begin
        count_d = ptr_width'(1);
        unf_set = 1'b1;
      end
    end else if (push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = !is_empty;
        top_d   = push_data;
        count_d = count_q + ptr_width'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_set = 1'b1;
      end else begin
        // Refill the top from the array; the last entry leaves the top at zero.
        top_d   = (count_q == ptr_width'(1)) ? '0 : mem_q[rd_idx];
        count_d = count_q - ptr_width'(1);
      end
    end

    ovf_d = (ovf_q && !clr_err) || ovf_set;
    unf_d = (unf_q && !clr_err) || unf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Array contents are only readable below count, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= top_q;
    end
  end

  assign rstack_top    = top_q;
  assign rstack_top_ip = top_q[iaddr_width-1:0];
  assign count         = count_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_rstack.sv
// tb/tb_rstack.sv - randomized self-checking bench for rstack against a queue model
module tb_rstack;

  localparam int IW = 10;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] ip_inc = '0;
  logic [DW-1:0] tos = '0;
  logic          push = 1'b0, push_tos_sel = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] rstack_top;
  logic [IW-1:0] rstack_top_ip;
  logic [PW-1:0] count;
  logic          empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  bit m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  rstack #(.iaddr_width(IW), .data_width(DW), .depth(DEPTH), .ptr_width(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ip_inc(ip_inc), .TOS(tos), .push(push),
    .push_tos_sel(push_tos_sel), .pop(pop), .clr_err(clr_err),
    .rstack_top(rstack_top), .rstack_top_ip(rstack_top_ip), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_top();
    return (mq.size() == 0) ? '0 : mq[mq.size()-1];
  endfunction

  task automatic check_all(input string tag);
    logic [DW-1:0] t;
    t = m_top();
    chk({tag, ".top"}, 32'(rstack_top), 32'(t));
    chk({tag, ".top_ip"}, 32'(rstack_top_ip), 32'(t[IW-1:0]));
    chk({tag, ".count"}, 32'(count), mq.size());
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_edge(input bit pu, input bit sel, input bit po, input bit clr,
                            input logic [IW-1:0] ip, input logic [DW-1:0] t);
    logic [DW-1:0] pd;
    pd = sel ? t : DW'(ip);
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (pu && po) begin
      if (mq.size() > 0) mq[mq.size()-1] = pd;
      else begin
        mq.push_back(pd);
        m_unf = 1;
      end
    end else if (pu) begin
      if (mq.size() < DEPTH) mq.push_back(pd);
      else m_ovf = 1;
    end else if (po) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else m_unf = 1;
    end
  endtask

  task automatic step(input string tag, input bit pu, input bit sel, input bit po, input bit clr,
                      input logic [IW-1:0] ip, input logic [DW-1:0] t);
    @(negedge clk);
    push = pu; push_tos_sel = sel; pop = po; clr_err = clr; ip_inc = ip; tos = t;
    @(posedge clk);
    #1;
    model_edge(pu, sel, po, clr, ip, t);
    check_all(tag);
    push = 0; pop = 0; clr_err = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step("idle", 0, 0, 0, 0, '0, '0);
    chk("idle.top0", 32'(rstack_top), 0);

    step("call1", 1, 0, 0, 0, 10'h012, '0);
    step("call2", 1, 0, 0, 0, 10'h034, '0);
    step("call3", 1, 0, 0, 0, 10'h056, '0);
    chk("call.top", 32'(rstack_top), 32'h0056);
    chk("call.count", 32'(count), 3);
    step("ret1", 0, 0, 1, 0, '0, '0);
    chk("ret1.top", 32'(rstack_top), 32'h0034);
    step("ret2", 0, 0, 1, 0, '0, '0);
    chk("ret2.top", 32'(rstack_top), 32'h0012);
    step("ret3", 0, 0, 1, 0, '0, '0);
    chk("ret3.top", 32'(rstack_top), 32'h0000);
    chk("ret3.empty", 32'(empty), 1);

    step("tor", 1, 1, 0, 0, 10'h155, 16'hBEEF);
    chk("tor.top", 32'(rstack_top), 32'hBEEF);
    step("repl", 1, 0, 1, 0, 10'h3FF, 16'h1234);
    chk("repl.top", 32'(rstack_top), 32'h03FF);
    chk("repl.count", 32'(count), 1);
    step("drain", 0, 0, 1, 0, '0, '0);

    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 1, 0, 0, '0, DW'(i));
    chk("fill.full", 32'(full), 1);
    chk("fill.top", 32'(rstack_top), 16);
    step("ovf", 1, 1, 0, 0, '0, 16'd99);
    chk("ovf.top", 32'(rstack_top), 16);
    chk("ovf.flag", 32'(overflow), 1);
    for (int i = DEPTH; i >= 1; i--) begin
      chk("unwind.top", 32'(rstack_top), i);
      step("unwind", 0, 0, 1, 0, '0, '0);
    end

    step("unf", 0, 0, 1, 0, '0, '0);
    chk("unf.flag", 32'(underflow), 1);
    step("clr", 0, 0, 0, 1, '0, '0);
    chk("clr.flag", 32'(underflow), 0);
    step("clrset", 0, 0, 1, 1, '0, '0);
    chk("clrset.flag", 32'(underflow), 1);
    step("pp_empty", 1, 0, 1, 0, 10'h2A5, '0);
    chk("pp_empty.top", 32'(rstack_top), 32'h02A5);
    step("clr2", 0, 0, 1, 1, '0, '0);

    for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 0, 0, IW'(i + 7), '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.top", 32'(rstack_top), 0);
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, '0, '0);

    for (int n = 0; n < 1500; n++) begin
      int ppush, ppop;
      case ((n / 100) % 3)
        0: begin ppush = 70; ppop = 25; end
        1: begin ppush = 25; ppop = 70; end
        default: begin ppush = 50; ppop = 50; end
      endcase
      step("rand", $urandom_range(0, 99) < ppush, $urandom_range(0, 1),
           $urandom_range(0, 99) < ppop, $urandom_range(0, 99) < 8,
           IW'($urandom), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
